multi_edge_sync: RTL and testbench

- Multi-channel synchroniser and event detector for asynchronous level inputs (sensor flags, external triggers), all landing in one clock domain.
- Per channel, in order: parametrised-depth synchroniser, optional glitch filter, mode-selectable edge detector, sticky pending flag and saturating event counter.
- Feeds CPU-side status/interrupt logic as the next generation of the single-bit rising-edge synchroniser.

---
 rtl/multi_edge_sync_pkg.sv | 21 ++
 rtl/edge_sync_chan.sv | 92 +++++++++
 rtl/multi_edge_sync.sv | 43 ++++
 tb/tb_multi_edge_sync.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_edge_sync_pkg.sv
// Shared types and helpers for the multi-channel edge synchroniser.
package multi_edge_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // 1 when a level toggle in the given direction qualifies under mode.
  function automatic logic edge_hit(input edge_mode_e mode, input logic rising);
    case (mode)
      EDGE_RISE: return rising;
      EDGE_FALL: return !rising;
      EDGE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_sync_chan.sv
// One channel: synchroniser chain, glitch filter, edge detect, sticky pending
// flag and saturating event counter.
module edge_sync_chan
  import multi_edge_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_i,
  input  edge_mode_e       mode_i,
  input  logic             filt_en_i,
  input  logic             pend_clr_i,
  input  logic             cnt_clr_i,
  output logic             level_o,
  output logic             pulse_o,
  output logic             pend_o,
  output logic [CNT_W-1:0] cnt_o
);

  // The level register doubles as the final synchroniser stage, so the
  // explicit chain is one flop shorter than SYNC_STAGES.
  localparam int unsigned CHAIN = SYNC_STAGES - 1;
  localparam int unsigned FW    = $clog2(FILTER_CYCLES + 1);

  logic [CHAIN-1:0] sync_q;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    thr;
  logic             s;
  logic             accept;
  logic             hit;

  assign s   = sync_q[CHAIN-1];
  assign thr = filt_en_i ? FW'(FILTER_CYCLES) : FW'(1);

  always_comb begin
    fcnt_d  = fcnt_q;
    level_d = level_q;
    accept  = 1'b0;
    if (s == level_q) begin
      fcnt_d = '0;
    end else if (fcnt_q >= thr - FW'(1)) begin
      // >= rather than == so a threshold drop mid-count accepts at once
      accept  = 1'b1;
      level_d = s;
      fcnt_d  = '0;
    end else begin
      fcnt_d = fcnt_q + FW'(1);
    end

    hit     = accept & edge_hit(mode_i, s);
    pulse_d = hit;
    pend_d  = hit | (pend_q & ~pend_clr_i);

    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fcnt_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= (sync_q << 1) | CHAIN'(async_i);
      fcnt_q  <= fcnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign pend_o  = pend_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/multi_edge_sync.sv
// Multi-channel asynchronous level synchroniser and event detector.
module multi_edge_sync
  import multi_edge_sync_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       async_in,
  input  logic [2*N_CH-1:0]     edge_mode,
  input  logic                  filt_en,
  input  logic [N_CH-1:0]       pend_clr,
  input  logic                  cnt_clr,
  output logic [N_CH-1:0]       sync_level,
  output logic [N_CH-1:0]       edge_pulse,
  output logic [N_CH-1:0]       pending,
  output logic [N_CH*CNT_W-1:0] evt_cnt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_sync_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst),
      .async_i   (async_in[i]),
      .mode_i    (edge_mode_e'(edge_mode[2*i +: 2])),
      .filt_en_i (filt_en),
      .pend_clr_i(pend_clr[i]),
      .cnt_clr_i (cnt_clr),
      .level_o   (sync_level[i]),
      .pulse_o   (edge_pulse[i]),
      .pend_o    (pending[i]),
      .cnt_o     (evt_cnt[CNT_W*i +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_edge_sync.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the per-channel event rules.
module tb_multi_edge_sync;

  localparam int N_CH = 4;
  localparam int SS   = 2;
  localparam int FC   = 4;
  localparam int CW   = 3;
  localparam int L    = SS - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       async_in;
  logic [2*N_CH-1:0]     edge_mode;
  logic                  filt_en;
  logic [N_CH-1:0]       pend_clr;
  logic                  cnt_clr;
  logic [N_CH-1:0]       sync_level;
  logic [N_CH-1:0]       edge_pulse;
  logic [N_CH-1:0]       pending;
  logic [N_CH*CW-1:0]    evt_cnt;

  always #5 clk = ~clk;

  multi_edge_sync #(
    .N_CH(N_CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .edge_mode(edge_mode),
    .filt_en(filt_en), .pend_clr(pend_clr), .cnt_clr(cnt_clr),
    .sync_level(sync_level), .edge_pulse(edge_pulse), .pending(pending),
    .evt_cnt(evt_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: input delayed by L samples, run length of disagreement with the
  // accepted level, accept after T consecutive disagreeing cycles.
  bit m_pipe  [N_CH][L];
  bit m_level [N_CH];
  int m_run   [N_CH];
  bit m_pulse [N_CH];
  bit m_pend  [N_CH];
  int m_cnt   [N_CH];

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      for (int j = 0; j < L; j++) m_pipe[c][j] = 1'b0;
      m_level[c] = 1'b0;
      m_run[c]   = 0;
      m_pulse[c] = 1'b0;
      m_pend[c]  = 1'b0;
      m_cnt[c]   = 0;
    end
  endtask

  task automatic model_edge();
    int t;
    t = filt_en ? FC : 1;
    for (int c = 0; c < N_CH; c++) begin
      bit d;
      bit hit;
      logic [1:0] md;
      d = m_pipe[c][0];
      for (int j = 0; j < L - 1; j++) m_pipe[c][j] = m_pipe[c][j+1];
      m_pipe[c][L-1] = async_in[c];
      hit = 1'b0;
      md  = edge_mode[2*c +: 2];
      if (d == m_level[c]) begin
        m_run[c] = 0;
      end else begin
        m_run[c]++;
        if (m_run[c] >= t) begin
          m_level[c] = d;
          m_run[c]   = 0;
          hit = (md == 2'd3) || (md == 2'd1 && d) || (md == 2'd2 && !d);
        end
      end
      m_pulse[c] = hit;
      if (hit) m_pend[c] = 1'b1;
      else if (pend_clr[c]) m_pend[c] = 1'b0;
      if (cnt_clr) m_cnt[c] = hit ? 1 : 0;
      else if (hit && m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
    end
  endtask

  task automatic compare_all();
    logic [N_CH-1:0]    e_lv, e_pu, e_pe;
    logic [N_CH*CW-1:0] e_cn;
    for (int c = 0; c < N_CH; c++) begin
      e_lv[c] = m_level[c];
      e_pu[c] = m_pulse[c];
      e_pe[c] = m_pend[c];
      e_cn[c*CW +: CW] = m_cnt[c][CW-1:0];
    end
    check_eq("sync_level", 64'(sync_level), 64'(e_lv));
    check_eq("edge_pulse", 64'(edge_pulse), 64'(e_pu));
    check_eq("pending",    64'(pending),    64'(e_pe));
    check_eq("evt_cnt",    64'(evt_cnt),    64'(e_cn));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive_rst_low();
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("rst_outputs_zero", 64'({sync_level, edge_pulse, pending, evt_cnt}), 64'd0);
    compare_all();
  endtask

  task automatic run_cycles(input int n, input int ch, inout int np, inout int first_hi,
                            inout int pulse_hi);
    for (int k = 1; k <= n; k++) begin
      cycle();
      if (edge_pulse[ch]) begin
        np++;
        if (sync_level[ch]) pulse_hi++;
      end
      if (sync_level[ch] && first_hi == 0) first_hi = k;
    end
  endtask

  initial begin
    int np, fh, ph;
    int cnp [N_CH];
    int cfp [N_CH];

    async_in  = '0;
    edge_mode = '0;
    filt_en   = 1'b1;
    pend_clr  = '0;
    cnt_clr   = 1'b0;
    rst       = 1'b1;
    #2;
    drive_rst_low();
    repeat (3) cycle();
    rst = 1'b1;

    // Filtered rising edge on ch0
    edge_mode   = 8'b00_00_00_01;
    async_in[0] = 1'b1;
    np = 0; fh = 0; ph = 0;
    run_cycles(20, 0, np, fh, ph);
    check_eq("ch0_latency_filt", 64'(fh), 64'd5);
    check_eq("ch0_pulse_count", 64'(np), 64'd1);
    check_eq("ch0_pending", 64'(pending[0]), 64'd1);
    check_eq("ch0_count", 64'(evt_cnt[0 +: CW]), 64'd1);

    // Glitch on ch1: rejected when filtered, two events when bypassed
    edge_mode[3:2] = 2'b11;
    np = 0; fh = 0; ph = 0;
    async_in[1] = 1'b1;
    run_cycles(3, 1, np, fh, ph);
    async_in[1] = 1'b0;
    run_cycles(10, 1, np, fh, ph);
    check_eq("ch1_glitch_pulses", 64'(np), 64'd0);
    check_eq("ch1_glitch_level", 64'(fh), 64'd0);
    check_eq("ch1_glitch_count", 64'(evt_cnt[CW +: CW]), 64'd0);
    filt_en = 1'b0;
    np = 0; fh = 0; ph = 0;
    async_in[1] = 1'b1;
    run_cycles(3, 1, np, fh, ph);
    async_in[1] = 1'b0;
    run_cycles(10, 1, np, fh, ph);
    check_eq("ch1_bypass_pulses", 64'(np), 64'd2);
    check_eq("ch1_bypass_latency", 64'(fh), 64'd2);
    check_eq("ch1_bypass_count", 64'(evt_cnt[CW +: CW]), 64'd2);

    // Falling-edge mode on ch2, square wave
    filt_en = 1'b1;
    edge_mode[5:4] = 2'b10;
    np = 0; fh = 0; ph = 0;
    for (int p = 0; p < 3; p++) begin
      async_in[2] = 1'b1;
      run_cycles(10, 2, np, fh, ph);
      async_in[2] = 1'b0;
      run_cycles(10, 2, np, fh, ph);
    end
    run_cycles(10, 2, np, fh, ph);
    check_eq("ch2_fall_pulses", 64'(np), 64'd3);
    check_eq("ch2_pulse_on_high", 64'(ph), 64'd0);
    check_eq("ch2_count", 64'(evt_cnt[2*CW +: CW]), 64'd3);

    // Saturation on ch3, then clear coincident with an event
    filt_en = 1'b0;
    edge_mode[7:6] = 2'b11;
    np = 0; fh = 0; ph = 0;
    for (int e = 0; e < 9; e++) begin
      async_in[3] = ~async_in[3];
      run_cycles(4, 3, np, fh, ph);
    end
    check_eq("ch3_edges", 64'(np), 64'd9);
    check_eq("ch3_saturated", 64'(evt_cnt[3*CW +: CW]), 64'd7);
    async_in[3] = ~async_in[3];
    cycle();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    check_eq("ch3_clr_pulse", 64'(edge_pulse[3]), 64'd1);
    check_eq("ch3_clr_with_evt", 64'(evt_cnt[3*CW +: CW]), 64'd1);
    check_eq("ch2_clr_no_evt", 64'(evt_cnt[2*CW +: CW]), 64'd0);
    repeat (3) cycle();

    // Pending set wins over simultaneous clear
    pend_clr[0] = 1'b1;
    cycle();
    pend_clr[0] = 1'b0;
    check_eq("ch0_pend_cleared", 64'(pending[0]), 64'd0);
    async_in[0] = 1'b0;
    repeat (4) cycle();
    check_eq("ch0_fall_no_pend", 64'(pending[0]), 64'd0);
    async_in[0] = 1'b1;
    cycle();
    pend_clr[0] = 1'b1;
    cycle();
    check_eq("ch0_set_pulse", 64'(edge_pulse[0]), 64'd1);
    check_eq("ch0_set_wins", 64'(pending[0]), 64'd1);
    cycle();
    pend_clr[0] = 1'b0;
    check_eq("ch0_clr_alone", 64'(pending[0]), 64'd0);

    // Random traffic against the model
    for (int k = 0; k < 800; k++) begin
      if (k % 50 == 0) begin
        edge_mode = 8'($urandom);
        filt_en   = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 4) == 0) async_in[c] = ~async_in[c];
        pend_clr[c] = ($urandom_range(0, 7) == 0);
      end
      cnt_clr = ($urandom_range(0, 39) == 0);
      cycle();
    end
    pend_clr = '0;
    cnt_clr  = 1'b0;

    // Reset with inputs high, aborted mid-count, then one event per channel
    edge_mode = 8'h55;
    filt_en   = 1'b1;
    drive_rst_low();
    async_in = '1;
    repeat (3) cycle();
    rst = 1'b1;
    repeat (3) cycle();
    drive_rst_low();
    cycle();
    rst = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      cnp[c] = 0;
      cfp[c] = 0;
    end
    for (int k = 1; k <= 15; k++) begin
      cycle();
      for (int c = 0; c < N_CH; c++) begin
        if (edge_pulse[c]) begin
          cnp[c]++;
          if (cfp[c] == 0) cfp[c] = k;
        end
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      check_eq($sformatf("rst_ch%0d_pulses", c), 64'(cnp[c]), 64'd1);
      check_eq($sformatf("rst_ch%0d_latency", c), 64'(cfp[c]), 64'd5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
